// File: rtl/indication_collector_if.sv
// indication_collector_if: per-channel heard() indications in, merged FIFO pop port and status out
interface indication_collector_if #(
  parameter int NCH = 4,
  parameter int DW = 32
);
  logic [NCH-1:0] heard_ena, heard_rdy;
  logic [NCH*DW-1:0] heard_meth, heard_v;
  logic deq_ena, deq_rdy;
  logic [3:0] deq_chan;
  logic [DW-1:0] deq_meth, deq_v;
  logic [31:0] heard_count;
  logic stop_main_program;
  modport master (
    output heard_ena, heard_meth, heard_v, deq_ena,
    input heard_rdy, deq_rdy, deq_chan, deq_meth, deq_v, heard_count, stop_main_program
  );
  modport slave (
    input heard_ena, heard_meth, heard_v, deq_ena,
    output heard_rdy, deq_rdy, deq_chan, deq_meth, deq_v, heard_count, stop_main_program
  );
endinterface

// File: rtl/indication_collector.sv
// indication_collector: NCH-channel heard() sink, round-robin merge into a shared FIFO, sticky stop flag
module indication_collector #(
  parameter int NCH = 4,
  parameter int DW = 32,
  parameter int DEPTH = 8,
  parameter logic [DW-1:0] STOP_METH = '1,
  parameter logic [31:0] STOP_COUNT = 32'd0
) (
  input logic CLK,
  input logic nRST,
  indication_collector_if.slave bus
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int AW = $clog2(DEPTH);
  logic [NCH-1:0] hold_valid, acc;
  logic [DW-1:0] hold_meth [NCH];
  logic [DW-1:0] hold_v [NCH];
  logic [3:0] mem_chan [DEPTH];
  logic [DW-1:0] mem_meth [DEPTH];
  logic [DW-1:0] mem_v [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [CW-1:0] ptr, gnt_idx;
  logic gnt_any, enq, pop, meth_hit, stop;
  logic [31:0] heard_count, cnt_nxt;
  logic [32:0] cnt_sum;
  int best_d, d;
  // nRST gating keeps every channel not-ready while reset is held
  assign bus.heard_rdy = {NCH{nRST & ~stop}} & ~hold_valid;
  assign acc = bus.heard_ena & bus.heard_rdy;
  assign bus.deq_rdy = count != '0;
  assign pop = bus.deq_ena & bus.deq_rdy;
  assign bus.deq_chan = bus.deq_rdy ? mem_chan[head] : '0;
  assign bus.deq_meth = bus.deq_rdy ? mem_meth[head] : '0;
  assign bus.deq_v = bus.deq_rdy ? mem_v[head] : '0;
  assign bus.heard_count = heard_count;
  assign bus.stop_main_program = stop;
  // grant goes to the valid hold with the smallest distance above ptr
  always_comb begin
    best_d = NCH;
    d = 0;
    gnt_idx = '0;
    meth_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      d = (i + NCH - int'(ptr)) % NCH;
      if (hold_valid[i] && d < best_d) begin
        best_d = d;
        gnt_idx = CW'(i);
      end
      meth_hit = meth_hit | (acc[i] && bus.heard_meth[i*DW +: DW] == STOP_METH);
    end
  end
  assign gnt_any = best_d < NCH;
  assign enq = gnt_any && count < (AW+1)'(DEPTH);
  assign cnt_sum = {1'b0, heard_count} + 33'($countones(acc));
  assign cnt_nxt = cnt_sum[32] ? '1 : cnt_sum[31:0];
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      ptr <= '0;
      heard_count <= '0;
      stop <= 1'b0;
    end else begin
      hold_valid <= (hold_valid & ~(enq ? NCH'(1) << gnt_idx : '0)) | acc;
      ptr <= enq ? (gnt_idx == CW'(NCH-1) ? '0 : gnt_idx + CW'(1)) : ptr;
      head <= head + AW'(pop);
      tail <= tail + AW'(enq);
      count <= count + (AW+1)'(enq) - (AW+1)'(pop);
      heard_count <= cnt_nxt;
      stop <= stop | meth_hit | (STOP_COUNT != 32'd0 && cnt_nxt >= STOP_COUNT);
    end
  end
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++)
      if (acc[i]) begin
        hold_meth[i] <= bus.heard_meth[i*DW +: DW];
        hold_v[i] <= bus.heard_v[i*DW +: DW];
      end
    if (enq) begin
      mem_chan[tail] <= 4'(gnt_idx);
      mem_meth[tail] <= hold_meth[gnt_idx];
      mem_v[tail] <= hold_v[gnt_idx];
    end
  end
endmodule

// File: tb/tb_indication_collector.sv
// tb_indication_collector: directed and random stimulus against a queue-based model of the collector
module tb_indication_collector;
  localparam int NCH = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] STOP_METH = 32'hFFFF_FFFF;
  typedef struct {logic [3:0] c; logic [31:0] m; logic [31:0] v;} ent_t;
  logic CLK, nRST;
  int checks, failures;
  logic [3:0] ena;
  logic [31:0] im [NCH];
  logic [31:0] iv [NCH];
  logic deq, rst_n;
  bit m_hv [NCH];
  logic [31:0] m_hm [NCH];
  logic [31:0] m_hd [NCH];
  int m_ptr;
  ent_t m_q [$];
  longint m_cnt;
  bit m_stop;
  indication_collector_if #(.NCH(NCH), .DW(32)) bus_a ();
  indication_collector_if #(.NCH(NCH), .DW(32)) bus_b ();
  indication_collector #(.NCH(NCH), .DW(32), .DEPTH(DEPTH), .STOP_METH(STOP_METH), .STOP_COUNT(32'd0))
    u_a (.CLK(CLK), .nRST(nRST), .bus(bus_a));
  indication_collector #(.NCH(NCH), .DW(32), .DEPTH(DEPTH), .STOP_METH(STOP_METH), .STOP_COUNT(32'd3))
    u_b (.CLK(CLK), .nRST(nRST), .bus(bus_b));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int held();
    int n = 0;
    for (int i = 0; i < NCH; i++) n += int'(m_hv[i]);
    return n;
  endfunction
  // one clock edge of the collector, expressed with a queue and per-channel slots
  function automatic void model_step();
    logic [3:0] a;
    int nacc = 0;
    bit hit = 0;
    bit full;
    if (!rst_n) begin
      m_hv = '{default: 0};
      m_q.delete();
      m_ptr = 0;
      m_cnt = 0;
      m_stop = 0;
      return;
    end
    for (int i = 0; i < NCH; i++) a[i] = ena[i] && !m_hv[i] && !m_stop;
    full = m_q.size() >= DEPTH;
    if (deq && m_q.size() > 0) m_q.delete(0);
    if (!full)
      for (int k = 0; k < NCH; k++) begin
        int j = (m_ptr + k) % NCH;
        if (m_hv[j]) begin
          m_q.push_back('{c: 4'(j), m: m_hm[j], v: m_hd[j]});
          m_hv[j] = 0;
          m_ptr = (j + 1) % NCH;
          break;
        end
      end
    for (int i = 0; i < NCH; i++)
      if (a[i]) begin
        m_hv[i] = 1;
        m_hm[i] = im[i];
        m_hd[i] = iv[i];
        nacc++;
        if (im[i] == STOP_METH) hit = 1;
      end
    m_cnt = m_cnt + nacc;
    if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
    m_stop = m_stop | hit;
  endfunction
  task automatic check_all();
    logic [3:0] er;
    bit ne;
    ne = m_q.size() > 0;
    for (int i = 0; i < NCH; i++) er[i] = rst_n && !m_hv[i] && !m_stop;
    chk("heard_rdy", bus_a.heard_rdy, er);
    chk("deq_rdy", bus_a.deq_rdy, ne);
    chk("deq_chan", bus_a.deq_chan, ne ? m_q[0].c : 4'd0);
    chk("deq_meth", bus_a.deq_meth, ne ? m_q[0].m : 32'd0);
    chk("deq_v", bus_a.deq_v, ne ? m_q[0].v : 32'd0);
    chk("heard_count", bus_a.heard_count, m_cnt[31:0]);
    chk("stop", bus_a.stop_main_program, m_stop);
  endtask
  task automatic cycle();
    for (int i = 0; i < NCH; i++) ena[i] = ena[i] & rst_n & ~m_hv[i] & ~m_stop;
    deq = deq & rst_n & (m_q.size() > 0);
    bus_a.heard_ena = ena;
    for (int i = 0; i < NCH; i++) begin
      bus_a.heard_meth[i*32 +: 32] = im[i];
      bus_a.heard_v[i*32 +: 32] = iv[i];
    end
    bus_a.deq_ena = deq;
    nRST = rst_n;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask
  initial begin
    int total;
    checks = 0;
    failures = 0;
    rst_n = 0;
    ena = '0;
    deq = 0;
    for (int i = 0; i < NCH; i++) begin
      im[i] = '0;
      iv[i] = '0;
    end
    bus_b.heard_ena = '0;
    bus_b.heard_meth = '0;
    bus_b.heard_v = '0;
    bus_b.deq_ena = 1'b0;
    cycle();
    cycle();
    chk("reset_rdy", bus_a.heard_rdy, 4'h0);
    chk("reset_deq_rdy", bus_a.deq_rdy, 1'b0);
    chk("reset_count", bus_a.heard_count, 32'd0);
    rst_n = 1;
    cycle();
    chk("post_reset_rdy", bus_a.heard_rdy, 4'hF);
    ena = 4'h1;
    im[0] = 32'd5;
    iv[0] = 32'h1234;
    cycle();
    ena = '0;
    chk("single_count", bus_a.heard_count, 32'd1);
    chk("single_not_yet", bus_a.deq_rdy, 1'b0);
    chk("single_rdy", bus_a.heard_rdy, 4'hE);
    cycle();
    chk("single_deq_rdy", bus_a.deq_rdy, 1'b1);
    chk("single_chan", bus_a.deq_chan, 4'd0);
    chk("single_meth", bus_a.deq_meth, 32'd5);
    chk("single_v", bus_a.deq_v, 32'h1234);
    deq = 1;
    cycle();
    deq = 0;
    chk("single_popped", bus_a.deq_rdy, 1'b0);
    rst_n = 0;
    cycle();
    rst_n = 1;
    ena = 4'hF;
    for (int i = 0; i < NCH; i++) begin
      im[i] = 32'd100 + 32'(i);
      iv[i] = $urandom;
    end
    cycle();
    ena = '0;
    repeat (4) cycle();
    for (int k = 0; k < NCH; k++) begin
      chk("rr_order", bus_a.deq_chan, 4'(k));
      deq = 1;
      cycle();
      deq = 0;
    end
    ena = 4'h3;
    cycle();
    ena = '0;
    repeat (2) cycle();
    chk("refill_first", bus_a.deq_chan, 4'd0);
    deq = 1;
    cycle();
    chk("refill_second", bus_a.deq_chan, 4'd1);
    cycle();
    deq = 0;
    ena = 4'hA;
    cycle();
    ena = '0;
    repeat (2) cycle();
    chk("ptr_at_2_first", bus_a.deq_chan, 4'd3);
    deq = 1;
    cycle();
    chk("ptr_at_2_second", bus_a.deq_chan, 4'd1);
    cycle();
    deq = 0;
    total = 0;
    for (int c = 0; c < 20 && total < 10; c++) begin
      ena = '0;
      for (int i = 0; i < NCH; i++)
        if (!m_hv[i] && !m_stop && total < 10) begin
          ena[i] = 1'b1;
          im[i] = $urandom;
          iv[i] = $urandom;
          total++;
        end
      cycle();
    end
    ena = '0;
    repeat (6) cycle();
    chk("full_deq_rdy", bus_a.deq_rdy, 1'b1);
    chk("full_held", $countones(~bus_a.heard_rdy), 2);
    deq = 1;
    cycle();
    deq = 0;
    chk("full_pop_no_enq", $countones(~bus_a.heard_rdy), 2);
    cycle();
    chk("full_slot_reused", $countones(~bus_a.heard_rdy), 1);
    for (int c = 0; c < 40 && !(m_q.size() == 3 && held() == 0); c++) begin
      deq = m_q.size() > 3;
      cycle();
    end
    for (int n = 0; n < 21; n++) begin
      ena = n < 20 ? 4'(1 << (n % NCH)) : 4'h0;
      im[n % NCH] = 32'd1000 + 32'(n);
      iv[n % NCH] = $urandom;
      deq = n >= 1;
      cycle();
    end
    ena = '0;
    deq = 0;
    chk("stream_head", bus_a.deq_meth, 32'd1017);
    repeat (3) begin
      deq = 1;
      cycle();
    end
    deq = 0;
    chk("stream_drained", bus_a.deq_rdy, 1'b0);
    ena = 4'h4;
    im[2] = STOP_METH;
    iv[2] = 32'hABCD;
    cycle();
    ena = '0;
    chk("meth_stop", bus_a.stop_main_program, 1'b1);
    chk("meth_stop_rdy", bus_a.heard_rdy, 4'h0);
    ena = 4'hF;
    cycle();
    ena = '0;
    chk("stop_entry_chan", bus_a.deq_chan, 4'd2);
    chk("stop_entry_meth", bus_a.deq_meth, STOP_METH);
    deq = 1;
    cycle();
    deq = 0;
    for (int n = 0; n < 400; n++) begin
      rst_n = $urandom_range(0, 49) != 0;
      ena = 4'($urandom);
      for (int i = 0; i < NCH; i++) begin
        im[i] = $urandom_range(0, 63) == 0 ? STOP_METH : $urandom;
        iv[i] = $urandom;
      end
      deq = n < 200 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 2) != 0;
      cycle();
    end
    ena = '0;
    deq = 0;
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    bus_b.heard_meth = '0;
    bus_b.heard_meth[31:0] = 32'd7;
    bus_b.heard_meth[63:32] = 32'd8;
    bus_b.heard_meth[95:64] = 32'd9;
    bus_b.heard_ena = 4'h1;
    cycle();
    bus_b.heard_ena = 4'h0;
    chk("cnt_stop_count1", bus_b.heard_count, 32'd1);
    chk("cnt_stop_idle1", bus_b.stop_main_program, 1'b0);
    bus_b.heard_ena = 4'h2;
    cycle();
    bus_b.heard_ena = 4'h0;
    chk("cnt_stop_count2", bus_b.heard_count, 32'd2);
    chk("cnt_stop_idle2", bus_b.stop_main_program, 1'b0);
    bus_b.heard_ena = 4'h4;
    cycle();
    bus_b.heard_ena = 4'h0;
    chk("cnt_stop_count3", bus_b.heard_count, 32'd3);
    chk("cnt_stop_set", bus_b.stop_main_program, 1'b1);
    chk("cnt_stop_rdy", bus_b.heard_rdy, 4'h0);
    chk("cnt_stop_queued", bus_b.deq_rdy, 1'b1);
    chk("cnt_stop_head", bus_b.deq_meth, 32'd7);
    rst_n = 0;
    cycle();
    chk("midrst_deq_rdy", bus_b.deq_rdy, 1'b0);
    chk("midrst_count", bus_b.heard_count, 32'd0);
    chk("midrst_stop", bus_b.stop_main_program, 1'b0);
    chk("midrst_rdy_low", bus_b.heard_rdy, 4'h0);
    rst_n = 1;
    cycle();
    chk("midrst_rdy_high", bus_b.heard_rdy, 4'hF);
    chk("midrst_deq_meth", bus_b.deq_meth, 32'd0);
    chk("midrst_deq_rdy_after", bus_b.deq_rdy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/indication_collector.md
Name: indication_collector

Overview:
- Parametrised successor to the single-channel "heard" indication sink.
- Accepts heard(meth, v) indications on NCH independent channels, each with a one-entry holding register.
- Channels are arbitrated round-robin into a shared DEPTH-entry FIFO, which a consumer drains via an ENA/RDY pop port.
- Raises a sticky stop_main_program when a configured stop method arrives or a configured indication count is reached.

Parameters:
- NCH, 4, number of indication channels (1..16).
- DW, 32, width of meth and v fields.
- DEPTH, 8, FIFO entries (power of 2, >=2).
- STOP_METH, 32'hFFFF_FFFF, meth value that triggers stop.
- STOP_COUNT, 0, accepted-indication count that triggers stop (0 = disabled).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- heard_ena  in  NCH  per-channel enable; asserted only while the matching heard_rdy is high.
- heard_meth  in  NCH*DW  per-channel meth, channel i at [i*DW +: DW].
- heard_v  in  NCH*DW  per-channel value, same packing.
- heard_rdy  out  NCH  per-channel ready.
- deq_ena  in  1  pop the FIFO head; asserted only while deq_rdy is high.
- deq_rdy  out  1  FIFO non-empty.
- deq_chan  out  4  channel index of the head entry.
- deq_meth  out  DW  meth of the head entry.
- deq_v  out  DW  v of the head entry.
- heard_count  out  32  total accepted indications, saturating at 32'hFFFF_FFFF.
- stop_main_program  out  1  sticky stop flag.

Behaviour:
- Reset (nRST low at posedge CLK) clears:
  - all hold_valid bits, the FIFO (head/tail/count = 0), and the round-robin pointer (0);
  - heard_count = 0, stop_main_program = 0.
  - Resulting outputs: heard_rdy = all 0 during reset and all 1 in the cycle after; deq_rdy = 0; deq_* = 0.
  - Reset mid-operation discards held and queued data; no pop occurs.
- heard_rdy[i] = !hold_valid[i] && !stop_main_program. It is purely registered state and never depends on any ENA.
- Accept: heard_ena[i] at edge t loads hold[i] = {meth, v}, sets hold_valid[i], and increments heard_count by 1 per accepting channel (up to NCH per cycle, saturating).
- Arbiter: each cycle, if the FIFO is not full (count < DEPTH):
  - pick the first valid hold scanning from ptr upward, wrapping modulo NCH;
  - enqueue {chan, meth, v} and clear that hold_valid;
  - set ptr = granted + 1 mod NCH.
  - If nothing is granted, ptr is unchanged. At most one enqueue per cycle.
- Latency: accepted at edge t -> enqueued at edge t+1 -> deq_rdy high after t+1 (2-edge minimum, empty FIFO).
- A hold register freed at edge t shows heard_rdy high after t, so a channel can sustain one accept per 2 cycles when uncontended.
- FIFO:
  - deq_* are driven from the registered head, valid only while deq_rdy.
  - Simultaneous enqueue and pop: count is unchanged and both pointers advance.
  - Full: no enqueue, even if deq_ena is high in the same cycle; the freed slot is usable next cycle.
  - Pointers wrap modulo DEPTH.
- Stop:
  - Set at the edge where an accepted indication has meth == STOP_METH, or where heard_count's next value >= STOP_COUNT (STOP_COUNT != 0).
  - Cleared only by reset.
  - Once set, all heard_rdy drop the next cycle. Held entries continue to enqueue and the FIFO continues to drain.
- Stop-triggering indications are still queued like any other.
- Simultaneous accepts on several channels in one edge are all captured; their order in the FIFO follows round-robin from ptr.

Test Plan:
- Reset then single accept: ch0 meth=5 v=0x1234 at edge 1 -> deq_rdy after edge 2 with chan=0, meth=5, v=0x1234; heard_count=1; pop -> deq_rdy=0.
- Round-robin fairness: all 4 channels hold data, ptr=0 -> enqueue order 0,1,2,3. Refill ch0 and ch1 while ptr=0 -> order 0 then 1; ptr ends at 2.
- Full FIFO: DEPTH=8, no pops, 10 indications across channels -> 8 queued, 2 remain held with heard_rdy low. One pop -> next edge enqueues one held entry; count stays 8.
- Simultaneous pop and enqueue at count=3 -> count stays 3, head advances, order preserved across pointer wrap (20 entries streamed, no loss or reorder).
- Stop by method: ch2 sends meth=32'hFFFF_FFFF -> stop_main_program=1 after that edge; all heard_rdy=0 the next cycle; the entry is still dequeued.
- Stop by count and reset mid-run: STOP_COUNT=3, 3 accepts -> stop at the 3rd accept edge. Then assert nRST low with 2 queued -> deq_rdy=0, heard_count=0, stop=0, heard_rdy all 1 after reset.
